// File: rtl/add_arbiter.sv
// add_arbiter: four requesters share a single W-bit adder through a small
// IDLE -> CALC -> HOLD state machine with round-robin grant selection.
// Optional feature macro: ADD_ARBITER_PRIO_EN gives requester 0 absolute
// priority, with requesters 1-3 rotating among themselves.

module add #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W:0]   C
);

  // Unsigned add that keeps the carry as the top result bit
  assign C = {1'b0, A} + {1'b0, B};

endmodule

module add_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_a,
  input  logic [4*W-1:0] req_b,
  output logic [3:0]     req_ready,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [W:0]     rsp_sum,
  input  logic           rsp_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [W-1:0] opA_q, opB_q;
  logic [1:0]   grant_q;
  logic [W:0]   rspSum_q;
  logic [1:0]   rspId_q;
  logic         rspValid_q;

  logic         grantFound;
  logic [1:0]   grantIdx;
  logic [1:0]   rrCand;
  logic [W-1:0] selA, selB;
  logic [W:0]   addC;
  logic         accept;
`ifdef ADD_ARBITER_PRIO_EN
  logic [2:0]   rrWide;
  logic [1:0]   prioBase;
`endif

  // Pick the requester to serve next, scanning from the rotating pointer
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = 2'd0;
    rrCand     = 2'd0;
`ifdef ADD_ARBITER_PRIO_EN
    rrWide     = 3'd0;
    prioBase   = (ptr_q == 2'd0) ? 2'd1 : ptr_q;
    if (req_valid[0]) begin
      grantFound = 1'b1;
      grantIdx   = 2'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        rrWide = {1'b0, prioBase} + 3'(k);
        if (rrWide > 3'd3) begin
          rrWide = rrWide - 3'd3;
        end
        rrCand = rrWide[1:0];
        if (!grantFound && req_valid[rrCand]) begin
          grantFound = 1'b1;
          grantIdx   = rrCand;
        end
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      rrCand = ptr_q + 2'(k);
      if (!grantFound && req_valid[rrCand]) begin
        grantFound = 1'b1;
        grantIdx   = rrCand;
      end
    end
`endif
  end

  // Steer the granted requester's operand slices toward the latches
  always_comb begin
    selA = '0;
    selB = '0;
    for (int k = 0; k < 4; k++) begin
      if (grantIdx == 2'(k)) begin
        selA = req_a[W*k +: W];
        selB = req_b[W*k +: W];
      end
    end
  end

  // Pointer value to adopt once the current result has been consumed
  always_comb begin
`ifdef ADD_ARBITER_PRIO_EN
    if (grant_q == 2'd0) begin
      ptr_d = ptr_q;
    end else if (grant_q == 2'd3) begin
      ptr_d = 2'd1;
    end else begin
      ptr_d = grant_q + 2'd1;
    end
`else
    ptr_d = grant_q + 2'd1;
`endif
  end

  // A transfer happens only from IDLE, and never while reset is asserted
  assign accept = (state_q == IDLE) && grantFound && !rst;

  // The single shared adder always works on the latched operands
  add #(.W(W)) uAdd (
    .A(opA_q),
    .B(opB_q),
    .C(addC)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grantFound) state_d = CALC;
      CALC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    req_ready = accept ? (4'b0001 << grantIdx) : 4'b0000;
    busy      = (state_q != IDLE);
  end

  // Operand latches, result registers and the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q      <= '0;
      opB_q      <= '0;
      grant_q    <= 2'd0;
      rspSum_q   <= '0;
      rspId_q    <= 2'd0;
      rspValid_q <= 1'b0;
      ptr_q      <= 2'd0;
    end else begin
      if (accept) begin
        opA_q   <= selA;
        opB_q   <= selB;
        grant_q <= grantIdx;
      end
      if (state_q == CALC) begin
        rspSum_q   <= addC;
        rspId_q    <= grant_q;
        rspValid_q <= 1'b1;
      end
      if ((state_q == HOLD) && rsp_ready) begin
        rspValid_q <= 1'b0;
        ptr_q      <= ptr_d;
      end
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_sum   = rspSum_q;

endmodule
